// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, I/O register map and default
// oversample ratio used by baud_gen, the transmitter and the receiver.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [1:0] ADDR_RXTX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/spart_rx_if.sv
// Processor-side bus of the SPART receiver: access controls in, byte and status out.
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 iocs;
  logic                 iorw;
  logic [1:0]           ioaddr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output iocs, iorw, ioaddr,
    input  rx_data, rda, frame_err, overrun
  );

  modport slave (
    input  iocs, iorw, ioaddr,
    output rx_data, rda, frame_err, overrun
  );
endinterface

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable.
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with rda / framing / overrun flags.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     rxd,
  spart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  logic                 rxd_s;
  rx_state_t            state, state_nxt;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 armed;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda, frame_err, overrun;
  logic                 rd, mid_tick, end_tick, last_bit;
  logic                 start_go, data_samp, load, clr_tick, clr_bit;

  spart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign rd       = bus.iocs & bus.iorw & (bus.ioaddr == ADDR_RXTX);
  assign mid_tick = en & (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign end_tick = en & (tick_cnt == TW'(OVERSAMPLE - 1));
  assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (armed && !rxd_s) state_nxt = START;
      START: if (mid_tick)        state_nxt = rxd_s ? IDLE : DATA;
      DATA:  if (end_tick && last_bit) state_nxt = STOP;
      STOP:  if (end_tick)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_go  = (state == IDLE) && armed && !rxd_s;
    data_samp = (state == DATA) && end_tick;
    load      = (state == STOP) && end_tick;
    clr_bit   = (state == START) && mid_tick;
    clr_tick  = start_go || clr_bit || (data_samp && last_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      armed     <= 1'b0;
      shreg     <= '0;
      rx_data   <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // armed only re-arms on an observed high line, so a held break cannot restart a frame
      if (state == IDLE) armed <= start_go ? 1'b0 : (armed | rxd_s);

      if (clr_tick)                    tick_cnt <= '0;
      else if (en && state != IDLE)    tick_cnt <= tick_cnt + 1'b1;

      if (clr_bit)        bit_cnt <= '0;
      else if (data_samp) bit_cnt <= bit_cnt + 1'b1;

      if (data_samp) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};

      // a load in the same cycle as a read keeps rda set and suppresses overrun
      if (load) begin
        rx_data   <= shreg;
        frame_err <= ~rxd_s;
        rda       <= 1'b1;
        if (rda && !rd) overrun <= 1'b1;
        else if (rd)    overrun <= 1'b0;
      end else if (rd) begin
        rda     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.rda       = rda;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART; the other end of the baud generator's `en` tick, which it consumes as a 16x-oversample strobe.
- Samples the asynchronous serial line `rxd`, validates the start bit, assembles an 8N1 frame LSB-first, and presents the byte to the processor-side bus.
- Exposes status flags: receive-data-available, framing error and overrun.
- Sits beside baud_gen and the transmitter inside the SPART top.

Parameters:
- OVERSAMPLE, 16, `en` ticks per bit period; power of two, at least 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  oversample tick from baud_gen; one-clk pulse
- rxd  in  1  asynchronous serial input; idle high
- iocs  in  1  chip select
- iorw  in  1  1 = read, 0 = write
- ioaddr  in  2  register select; 2'b00 = receive buffer, 2'b01 = status
- rx_data  out  DATA_BITS  last received byte
- rda  out  1  receive data available
- frame_err  out  1  stop bit of the last frame sampled low
- overrun  out  1  new byte loaded while rda was already 1

Behaviour:
- Reset (async, rst_n = 0):
  - All outputs are 0.
  - Synchronizer flops are 1.
  - State is IDLE; counters are 0; armed is 0.
- Synchronizer: `rxd` passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits; it advances only on `en`.
  - bit_cnt is $clog2(DATA_BITS) bits.
- Read strobe: rd = iocs & iorw & (ioaddr == 2'b00).
- State IDLE:
  - armed is set when rxd_s == 1.
  - If armed & rxd_s == 0: go to START, clear tick_cnt and armed.
  - `en` is not required to leave IDLE.
- State START:
  - On the `en` at which tick_cnt == OVERSAMPLE/2-1 (the mid-bit point), sample rxd_s.
  - If the sample is 0: go to DATA, clear tick_cnt and bit_cnt.
  - If the sample is 1 (glitch/false start): go to IDLE. No flags change.
- State DATA:
  - On the `en` at which tick_cnt == OVERSAMPLE-1, shift rxd_s into the shift register MSB (LSB-first line order) and increment bit_cnt.
  - After DATA_BITS samples, go to STOP with tick_cnt cleared.
- State STOP:
  - On the `en` at which tick_cnt == OVERSAMPLE-1, sample rxd_s and go to IDLE.
  - Load rx_data from the shift register.
  - frame_err is set to NOT sample; it is overwritten every frame.
  - rda is set to 1.
  - If rda was 1 and there is no rd in the same cycle, overrun is set to 1.
- Load latency: rda, rx_data and frame_err update at the clk edge following the stop-sample `en` cycle.
- Read clear: rd clears rda and overrun at the next edge.
  - rd and load in the same cycle: load wins; rda stays 1, overrun is not set, and rx_data takes the new byte.
- Break (line held low after a framing error): armed prevents a restart until rxd_s has been observed high.
- `en` low: the FSM holds counters and state. Only the IDLE exit and the synchronizer advance.
- Reset mid-frame: the partial frame is discarded and no flags are set.
- Writes (iorw = 0) and ioaddr 2'b01 have no side effects here. The top muxes the status as {frame_err, overrun, rda} onto its databus.

Decomposition:
- spart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - ioaddr constants: ADDR_RXTX = 2'b00, ADDR_STATUS = 2'b01, ADDR_DB_LO = 2'b10, ADDR_DB_HI = 2'b11 (shared with baud_gen and the transmitter).
  - OVERSAMPLE default.
- One sub-module, spart_sync2: a 2-flop synchronizer with reset value parameter 1. It is reused by the transmitter's CTS path.

Test Plan:
- Reset behaviour: Drive rst_n = 0 mid-frame (after 3 data bits of 0x5A), then release and send 0x3C -> no rda during or after reset; 0x3C is received cleanly with rda = 1 and frame_err = 0.
- Nominal byte: `en` = 1 every clk (1 bit = 16 clks). Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rda = 1 exactly 1 clk after the 16th tick of the stop bit; rx_data = 0xA5; frame_err = 0; overrun = 0. Then rd -> rda = 0 on the next edge.
- False start: Pulse rxd low for 5 ticks, then high -> FSM returns to IDLE; no rda. A following 0x0F is received correctly.
- Framing error / break: Send 0x81 with the stop bit low and hold rxd low for 40 ticks -> rx_data = 0x81, frame_err = 1, rda = 1, no second frame started. After rxd goes high, send 0x7E -> frame_err = 0.
- Overrun and rd/load collision: Send 0x11 then 0x22 without reading -> rx_data = 0x22, overrun = 1. Repeat with rd asserted on the exact load cycle of 0x33 -> rda = 1, overrun = 0, rx_data = 0x33.
- Slow `en`: Pulse `en` once every 4 clks and send 0xC3 -> rx_data = 0xC3; total frame ≈ 10 × 16 × 4 clks.
